wb_master_arbiter: RTL and testbench
====================================

// Module: wb_master_arbiter
// PURPOSE
//  Two-master to one-slave Wishbone arbiter in front of the wb_cross_clk/compressor path.
//  Lets a second master (DMA/debug) share the off-chip bus with upper_core.
//  Round-robin grant, held for a whole CYC (including 4/8-beat bursts); pure mux in data path.
// PARAMETERS
//  TIMEOUT_CYCLES  255  stall limit (cycles of STB without ACK/ERR/RTY); used only with WB_ARB_TIMEOUT_EN
//  TO_W            8    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  i_clk                    in   1           single clock; all logic on posedge
//  i_rst                    in   1           synchronous, active-high reset
//  mN_wb_cyc/stb/we         in   1 each      master N (N=0,1) bus controls
//  mN_wb_4_burst/8_burst    in   1 each      master N burst hints
//  mN_wb_adr                in   `WB_ADDR_W  master N address
//  mN_wb_o_dat              in   16          master N write data
//  mN_wb_sel                in   2           master N byte select
//  mN_wb_i_dat              out  16          read data to master N
//  mN_wb_ack/err/rty        out  1 each      responses to master N
//  s_wb_cyc/stb/we          out  1 each      to slave
//  s_wb_4_burst/8_burst     out  1 each      to slave
//  s_wb_adr                 out  `WB_ADDR_W  to slave
//  s_wb_o_dat               out  16          to slave
//  s_wb_sel                 out  2           to slave
//  s_wb_i_dat               in   16          from slave
//  s_wb_ack/err/rty         in   1 each      from slave
//  gnt                      out  2           one-hot current grant (debug)
// BEHAVIOUR
//  Reset: state=IDLE, last=1 (m0 wins first tie), gnt=0.
//   All s_wb_* outputs 0; all mN_wb_ack/err/rty 0; mN_wb_i_dat = s_wb_i_dat (unqualified).
//  States:
//   IDLE: if any mN_wb_cyc, register grant -> G0/G1 at next edge (1-cycle arbitration latency).
//   G0, G1: hold while granted master's cyc=1.
//   G0, G1: granted cyc=0 -> IDLE and last<=granted; no re-grant in that same cycle.
//  Tie (both cyc=1 in IDLE): grant master != last. Single requester: granted regardless of last.
//  Slave outputs driven combinationally from granted master only while in G0/G1;
//   s_wb_cyc/stb = granted m_cyc/stb, everything else muxed. In IDLE, s_wb_cyc=s_wb_stb=0.
//  Responses: granted master gets s_wb_ack/err/rty combinationally (zero added latency);
//   non-granted master always sees ack=err=rty=0.
//  Bursts: grant never changes while granted cyc=1, so 4/8-beat bursts are atomic.
//  Granted master dropping cyc mid-burst ends grant normally; slave sees cyc fall the same cycle.
//  Reset mid-transfer: at the reset edge grant drops and s_wb_cyc=0 next cycle; no response forwarded.
//  Losing master simply waits (its cyc stays high); it is granted on the next IDLE cycle.
//   No starvation: max wait = one foreign CYC + 2 cycles.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - TO_W counter increments each cycle with s_wb_cyc&s_wb_stb & !(ack|err|rty); cleared otherwise.
//   - On reaching TIMEOUT_CYCLES: one-cycle mN_wb_err=1 to granted master.
//   - Same cycle: s_wb_cyc/stb forced 0; next state=IDLE, last<=granted, counter cleared.
//   - Late slave ack after abort is dropped.
//  WB_ARB_TIMEOUT_EN undefined:
//   - No counter; a stalled slave holds the grant indefinitely.
//   - TIMEOUT_CYCLES/TO_W unused.
// TESTING
//  1. Reset, m0 read adr 'h000100, slave acks 'hBEEF after 2 cycles
//     -> gnt=01 one cycle after cyc; m0 ack with i_dat 'hBEEF; m1 sees ack=0.
//  2. Both cyc=1 same cycle out of reset -> m0 served first, then m1.
//     Next tie -> m0 again only if m1 was last (alternation checked over 4 rounds).
//  3. m1 8-beat burst (8 acks) with m0 requesting from beat 2 -> gnt stays 10 for all 8 acks;
//     m0 granted 2 cycles after m1 drops cyc.
//  4. i_rst asserted mid-m0 write -> next cycle s_wb_cyc=0, gnt=00, no ack to m0;
//     post-reset tie -> m0 granted.
//  5. Slave err/rty on m1 transfer -> forwarded to m1 only, same cycle; m0 unaffected.
//  6. (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) slave never acks
//     -> m0 err pulse at 16th stall cycle, s_wb_cyc low same cycle, m1 then granted.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// ----------------------------------------------------------------------------
// wb_master_arbiter
//
// Two-master to one-slave Wishbone arbiter. It sits in front of the
// wb_cross_clk/compressor path so that a DMA/debug master can share the
// off-chip bus with upper_core.
//
// Arbitration is round-robin. A grant is held for a complete CYC, which makes
// 4/8-beat bursts atomic. The data path is a pure combinational mux, so
// requests and responses see no added latency once a master is granted.
//
// Optional build macro:
//   WB_ARB_TIMEOUT_EN  - when defined, a stall counter aborts a transfer that
//                        has waited TIMEOUT_CYCLES cycles with STB high and no
//                        ACK/ERR/RTY. The granted master gets a one-cycle ERR
//                        and the grant is released.
//
// Parameters:
//   TIMEOUT_CYCLES  stall limit (timeout build only)
//   TO_W            stall counter width; must be able to hold TIMEOUT_CYCLES
//
// Ports:
//   i_clk, i_rst              clock; synchronous active-high reset
//   mN_wb_cyc/stb/we          master N bus controls (N = 0, 1)
//   mN_wb_4_burst/8_burst     master N burst hints
//   mN_wb_adr/o_dat/sel       master N address, write data, byte select
//   mN_wb_i_dat               read data to master N (slave data, unqualified)
//   mN_wb_ack/err/rty         responses to master N
//   s_wb_*                    slave side of the same signal set
//   gnt                       one-hot current grant {m1, m0}
// ----------------------------------------------------------------------------
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

module wb_master_arbiter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   // master 0
   input  logic                  m0_wb_cyc,
   input  logic                  m0_wb_stb,
   input  logic                  m0_wb_we,
   input  logic                  m0_wb_4_burst,
   input  logic                  m0_wb_8_burst,
   input  logic [`WB_ADDR_W-1:0] m0_wb_adr,
   input  logic [15:0]           m0_wb_o_dat,
   input  logic [1:0]            m0_wb_sel,
   output logic [15:0]           m0_wb_i_dat,
   output logic                  m0_wb_ack,
   output logic                  m0_wb_err,
   output logic                  m0_wb_rty,
   // master 1
   input  logic                  m1_wb_cyc,
   input  logic                  m1_wb_stb,
   input  logic                  m1_wb_we,
   input  logic                  m1_wb_4_burst,
   input  logic                  m1_wb_8_burst,
   input  logic [`WB_ADDR_W-1:0] m1_wb_adr,
   input  logic [15:0]           m1_wb_o_dat,
   input  logic [1:0]            m1_wb_sel,
   output logic [15:0]           m1_wb_i_dat,
   output logic                  m1_wb_ack,
   output logic                  m1_wb_err,
   output logic                  m1_wb_rty,
   // slave
   output logic                  s_wb_cyc,
   output logic                  s_wb_stb,
   output logic                  s_wb_we,
   output logic                  s_wb_4_burst,
   output logic                  s_wb_8_burst,
   output logic [`WB_ADDR_W-1:0] s_wb_adr,
   output logic [15:0]           s_wb_o_dat,
   output logic [1:0]            s_wb_sel,
   input  logic [15:0]           s_wb_i_dat,
   input  logic                  s_wb_ack,
   input  logic                  s_wb_err,
   input  logic                  s_wb_rty,
   // debug
   output logic [1:0]            gnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G0   = 2'd1,
      ST_G1   = 2'd2
   } state_t;

   state_t state_reg, state_next;
   logic   last_reg, last_next;   // index of the master served most recently

   logic gnt_m0, gnt_m1;
   logic g_cyc, g_stb;            // CYC/STB of whichever master holds the grant
   logic abort;                   // stall timeout fires this cycle
   logic fwd;                     // slave responses may reach the granted master

   // Reject a counter too narrow to ever reach the limit.
   if (TO_W < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** TO_W) - 1) begin : g_bad_cfg
      $error("wb_master_arbiter: TO_W cannot hold TIMEOUT_CYCLES");
   end

   assign gnt_m0 = (state_reg == ST_G0);
   assign gnt_m1 = (state_reg == ST_G1);
   assign gnt    = {gnt_m1, gnt_m0};

   assign g_cyc = (gnt_m0 & m0_wb_cyc) | (gnt_m1 & m1_wb_cyc);
   assign g_stb = (gnt_m0 & m0_wb_stb) | (gnt_m1 & m1_wb_stb);

`ifdef WB_ARB_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_reg;
   logic            stall;

   // The stall is taken from the granted master's raw CYC/STB, not from
   // s_wb_cyc/stb, because the abort itself forces those low.
   assign stall = g_cyc & g_stb & ~(s_wb_ack | s_wb_err | s_wb_rty);
   assign abort = stall & ~i_rst & (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst || !stall || abort) begin
         to_cnt_reg <= '0;
      end else begin
         to_cnt_reg <= to_cnt_reg + 1'b1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
         last_reg  <= 1'b1;       // m0 wins the first tie
      end else begin
         state_reg <= state_next;
         last_reg  <= last_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      last_next  = last_reg;
      case (state_reg)
         ST_IDLE: begin
            if (m0_wb_cyc && m1_wb_cyc) begin
               state_next = last_reg ? ST_G0 : ST_G1;
            end else if (m0_wb_cyc) begin
               state_next = ST_G0;
            end else if (m1_wb_cyc) begin
               state_next = ST_G1;
            end
         end
         // Release always passes through IDLE, so the other master is
         // considered on the following cycle and never starves.
         ST_G0: begin
            if (!m0_wb_cyc || abort) begin
               state_next = ST_IDLE;
               last_next  = 1'b0;
            end
         end
         ST_G1: begin
            if (!m1_wb_cyc || abort) begin
               state_next = ST_IDLE;
               last_next  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------- data path
   assign s_wb_cyc     = g_cyc & ~abort;
   assign s_wb_stb     = g_stb & ~abort;
   assign s_wb_we      = (gnt_m0 & m0_wb_we)      | (gnt_m1 & m1_wb_we);
   assign s_wb_4_burst = (gnt_m0 & m0_wb_4_burst) | (gnt_m1 & m1_wb_4_burst);
   assign s_wb_8_burst = (gnt_m0 & m0_wb_8_burst) | (gnt_m1 & m1_wb_8_burst);
   assign s_wb_adr     = gnt_m0 ? m0_wb_adr   : (gnt_m1 ? m1_wb_adr   : '0);
   assign s_wb_o_dat   = gnt_m0 ? m0_wb_o_dat : (gnt_m1 ? m1_wb_o_dat : '0);
   assign s_wb_sel     = gnt_m0 ? m0_wb_sel   : (gnt_m1 ? m1_wb_sel   : '0);

   // Read data is broadcast; only the qualifiers are steered.
   assign m0_wb_i_dat = s_wb_i_dat;
   assign m1_wb_i_dat = s_wb_i_dat;

   // Nothing is forwarded while reset is applied or while a timeout aborts.
   assign fwd = ~i_rst & ~abort;

   assign m0_wb_ack = gnt_m0 & s_wb_ack & fwd;
   assign m0_wb_err = gnt_m0 & ((s_wb_err & fwd) | abort);
   assign m0_wb_rty = gnt_m0 & s_wb_rty & fwd;
   assign m1_wb_ack = gnt_m1 & s_wb_ack & fwd;
   assign m1_wb_err = gnt_m1 & ((s_wb_err & fwd) | abort);
   assign m1_wb_rty = gnt_m1 & s_wb_rty & fwd;

endmodule

// File: tb/tb_wb_master_arbiter.sv
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif

module tb_wb_master_arbiter;

   localparam int AW = `WB_ADDR_W;
   localparam logic [AW-1:0] A0 = AW'(24'h000100);
   localparam logic [AW-1:0] A1 = AW'(24'h000200);
   localparam logic [15:0]   D0 = 16'h1111;
   localparam logic [15:0]   D1 = 16'h2222;

   logic          i_clk, i_rst;
   logic          m0_wb_cyc, m0_wb_stb, m0_wb_we, m0_wb_4_burst, m0_wb_8_burst;
   logic [AW-1:0] m0_wb_adr;
   logic [15:0]   m0_wb_o_dat, m0_wb_i_dat;
   logic [1:0]    m0_wb_sel;
   logic          m0_wb_ack, m0_wb_err, m0_wb_rty;
   logic          m1_wb_cyc, m1_wb_stb, m1_wb_we, m1_wb_4_burst, m1_wb_8_burst;
   logic [AW-1:0] m1_wb_adr;
   logic [15:0]   m1_wb_o_dat, m1_wb_i_dat;
   logic [1:0]    m1_wb_sel;
   logic          m1_wb_ack, m1_wb_err, m1_wb_rty;
   logic          s_wb_cyc, s_wb_stb, s_wb_we, s_wb_4_burst, s_wb_8_burst;
   logic [AW-1:0] s_wb_adr;
   logic [15:0]   s_wb_o_dat, s_wb_i_dat;
   logic [1:0]    s_wb_sel;
   logic          s_wb_ack, s_wb_err, s_wb_rty;
   logic [1:0]    gnt;

   wb_master_arbiter #(.TIMEOUT_CYCLES(16), .TO_W(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .m0_wb_cyc(m0_wb_cyc), .m0_wb_stb(m0_wb_stb), .m0_wb_we(m0_wb_we),
      .m0_wb_4_burst(m0_wb_4_burst), .m0_wb_8_burst(m0_wb_8_burst),
      .m0_wb_adr(m0_wb_adr), .m0_wb_o_dat(m0_wb_o_dat), .m0_wb_sel(m0_wb_sel),
      .m0_wb_i_dat(m0_wb_i_dat), .m0_wb_ack(m0_wb_ack), .m0_wb_err(m0_wb_err),
      .m0_wb_rty(m0_wb_rty),
      .m1_wb_cyc(m1_wb_cyc), .m1_wb_stb(m1_wb_stb), .m1_wb_we(m1_wb_we),
      .m1_wb_4_burst(m1_wb_4_burst), .m1_wb_8_burst(m1_wb_8_burst),
      .m1_wb_adr(m1_wb_adr), .m1_wb_o_dat(m1_wb_o_dat), .m1_wb_sel(m1_wb_sel),
      .m1_wb_i_dat(m1_wb_i_dat), .m1_wb_ack(m1_wb_ack), .m1_wb_err(m1_wb_err),
      .m1_wb_rty(m1_wb_rty),
      .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
      .s_wb_4_burst(s_wb_4_burst), .s_wb_8_burst(s_wb_8_burst),
      .s_wb_adr(s_wb_adr), .s_wb_o_dat(s_wb_o_dat), .s_wb_sel(s_wb_sel),
      .s_wb_i_dat(s_wb_i_dat), .s_wb_ack(s_wb_ack), .s_wb_err(s_wb_err),
      .s_wb_rty(s_wb_rty),
      .gnt(gnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // stim = {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_rty}
   // cs   = {s_wb_cyc, s_wb_stb};  r0/r1 = {ack, err, rty} seen by m0/m1
   typedef struct packed {
      logic [7:0] stim;
      logic [1:0] gnt;
      logic [1:0] cs;
      logic [2:0] r0;
      logic [2:0] r1;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic [7:0] stim, input logic [1:0] g,
                               input logic [1:0] cs, input logic [2:0] r0,
                               input logic [2:0] r1);
      vec_t v;
      v.stim = stim; v.gnt = g; v.cs = cs; v.r0 = r0; v.r1 = r1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        v;
      logic [63:0] exp_mux;

      i_rst = 1'b1;
      {m0_wb_cyc, m0_wb_stb, m0_wb_we, m0_wb_4_burst, m0_wb_8_burst} = '0;
      {m1_wb_cyc, m1_wb_stb, m1_wb_4_burst, m1_wb_8_burst} = '0;
      m1_wb_we = 1'b1;
      m0_wb_adr = A0; m0_wb_o_dat = D0; m0_wb_sel = 2'b01;
      m1_wb_adr = A1; m1_wb_o_dat = D1; m1_wb_sel = 2'b11;
      s_wb_i_dat = 16'h0; {s_wb_ack, s_wb_err, s_wb_rty} = '0;
      tick;

      // reset state
      tbl.push_back(mk(8'b1000_0000, 2'b00, 2'b00, 3'b000, 3'b000));
      // 1: m0 read, slave acks after 2 cycles
      tbl.push_back(mk(8'b0110_0000, 2'b00, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0110_0000, 2'b01, 2'b11, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0110_0100, 2'b01, 2'b11, 3'b100, 3'b000));
      tbl.push_back(mk(8'b0000_0000, 2'b01, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0000_0000, 2'b00, 2'b00, 3'b000, 3'b000));
      // 2: reset, then tie -> m0 first, loser waits and is served next
      tbl.push_back(mk(8'b1000_0000, 2'b00, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0111_1000, 2'b00, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0111_1100, 2'b01, 2'b11, 3'b100, 3'b000));
      tbl.push_back(mk(8'b0001_1000, 2'b01, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0001_1000, 2'b00, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0001_1100, 2'b10, 2'b11, 3'b000, 3'b100));
      tbl.push_back(mk(8'b0000_0000, 2'b10, 2'b00, 3'b000, 3'b000));
      //    round 2: last=m1 -> m0
      tbl.push_back(mk(8'b0111_1000, 2'b00, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0111_1100, 2'b01, 2'b11, 3'b100, 3'b000));
      tbl.push_back(mk(8'b0000_0000, 2'b01, 2'b00, 3'b000, 3'b000));
      //    round 3: last=m0 -> m1
      tbl.push_back(mk(8'b0111_1000, 2'b00, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0111_1100, 2'b10, 2'b11, 3'b000, 3'b100));
      tbl.push_back(mk(8'b0000_0000, 2'b10, 2'b00, 3'b000, 3'b000));
      //    round 4: last=m1 -> m0
      tbl.push_back(mk(8'b0111_1000, 2'b00, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0111_1100, 2'b01, 2'b11, 3'b100, 3'b000));
      tbl.push_back(mk(8'b0000_0000, 2'b01, 2'b00, 3'b000, 3'b000));
      // 5: err/rty on m1 forwarded to m1 only, m0 waiting
      tbl.push_back(mk(8'b0001_1000, 2'b00, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0111_1010, 2'b10, 2'b11, 3'b000, 3'b010));
      tbl.push_back(mk(8'b0111_1001, 2'b10, 2'b11, 3'b000, 3'b001));
      tbl.push_back(mk(8'b0110_0000, 2'b10, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0110_0000, 2'b00, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0110_0100, 2'b01, 2'b11, 3'b100, 3'b000));
      tbl.push_back(mk(8'b0000_0000, 2'b01, 2'b00, 3'b000, 3'b000));
      tbl.push_back(mk(8'b0000_0000, 2'b00, 2'b00, 3'b000, 3'b000));

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         {i_rst, m0_wb_cyc, m0_wb_stb, m1_wb_cyc, m1_wb_stb,
          s_wb_ack, s_wb_err, s_wb_rty} = v.stim;
         s_wb_i_dat = 16'hBE00 + 16'(i);
         #1;
         case (v.gnt)
            2'b01:   exp_mux = 64'({A0, D0, 1'b0, 2'b01, 1'b0, 1'b0, s_wb_i_dat});
            2'b10:   exp_mux = 64'({A1, D1, 1'b1, 2'b11, 1'b0, 1'b0, s_wb_i_dat});
            default: exp_mux = 64'({{AW{1'b0}}, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0, s_wb_i_dat});
         endcase
         chk($sformatf("row%0d_ctl", i),
             64'({gnt, s_wb_cyc, s_wb_stb, m0_wb_ack, m0_wb_err, m0_wb_rty,
                  m1_wb_ack, m1_wb_err, m1_wb_rty, m1_wb_i_dat}),
             64'({v.gnt, v.cs, v.r0, v.r1, s_wb_i_dat}));
         chk($sformatf("row%0d_mux", i),
             64'({s_wb_adr, s_wb_o_dat, s_wb_we, s_wb_sel, s_wb_4_burst,
                  s_wb_8_burst, m0_wb_i_dat}),
             exp_mux);
         tick;
      end
      {i_rst, s_wb_ack, s_wb_err, s_wb_rty} = '0;

      // 3: m1 8-beat burst, m0 requests from beat 2 onwards
      m1_wb_cyc = 1'b1; m1_wb_stb = 1'b1; m1_wb_8_burst = 1'b1;
      #1;
      chk("burst_arb_gnt", 64'(gnt), 64'(2'b00));
      tick;
      for (int k = 0; k < 8; k++) begin
         m0_wb_cyc = (k >= 1); m0_wb_stb = (k >= 1);
         s_wb_ack = 1'b1;
         #1;
         chk($sformatf("burst_beat%0d", k),
             64'({gnt, m1_wb_ack, m0_wb_ack, s_wb_8_burst, s_wb_cyc}),
             64'({2'b10, 1'b1, 1'b0, 1'b1, 1'b1}));
         tick;
      end
      m1_wb_cyc = 1'b0; m1_wb_stb = 1'b0; m1_wb_8_burst = 1'b0; s_wb_ack = 1'b0;
      #1;
      chk("burst_drop", 64'({gnt, s_wb_cyc}), 64'({2'b10, 1'b0}));
      tick;
      chk("burst_idle", 64'(gnt), 64'(2'b00));
      tick;
      chk("burst_m0_gnt", 64'({gnt, s_wb_cyc}), 64'({2'b01, 1'b1}));
      m0_wb_cyc = 1'b0; m0_wb_stb = 1'b0;
      tick;
      tick;

      // 4: reset in the middle of an m0 write
      m0_wb_cyc = 1'b1; m0_wb_stb = 1'b1; m0_wb_we = 1'b1;
      tick;
      chk("rst_pre", 64'({gnt, s_wb_cyc, s_wb_we}), 64'({2'b01, 1'b1, 1'b1}));
      i_rst = 1'b1;
      tick;
      i_rst = 1'b0;
      m1_wb_cyc = 1'b1; m1_wb_stb = 1'b1; s_wb_ack = 1'b1;
      #1;
      chk("rst_post", 64'({gnt, s_wb_cyc, m0_wb_ack, m1_wb_ack}), 64'({2'b00, 3'b000}));
      tick;
      s_wb_ack = 1'b0;
      #1;
      chk("rst_tie_m0", 64'(gnt), 64'(2'b01));
      {m0_wb_cyc, m0_wb_stb, m0_wb_we, m1_wb_cyc, m1_wb_stb} = '0;
      tick;
      tick;

`ifdef WB_ARB_TIMEOUT_EN
      // 6: slave never answers; m0 aborted on the 16th stall cycle
      m0_wb_cyc = 1'b1; m0_wb_stb = 1'b1;
      tick;
      for (int k = 1; k <= 16; k++) begin
         if (k == 3) begin
            m1_wb_cyc = 1'b1; m1_wb_stb = 1'b1;
         end
         #1;
         chk($sformatf("to_stall%0d", k), 64'({m0_wb_err, s_wb_cyc, gnt}),
             (k == 16) ? 64'({1'b1, 1'b0, 2'b01}) : 64'({1'b0, 1'b1, 2'b01}));
         tick;
      end
      s_wb_ack = 1'b1;
      #1;
      chk("to_late_ack", 64'({gnt, m0_wb_ack, s_wb_cyc}), 64'({2'b00, 1'b0, 1'b0}));
      s_wb_ack = 1'b0;
      tick;
      chk("to_m1_gnt", 64'(gnt), 64'(2'b10));
      {m0_wb_cyc, m0_wb_stb, m1_wb_cyc, m1_wb_stb} = '0;
      tick;
      tick;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
